// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : mac_accumulator
//  Description : Accumulation stage of the MAC unit. Sums a stream of signed
//                terms (valid/ready) into a wide accumulator and presents the
//                result with a term count and a sticky overflow flag.
//                Define MAC_ACC_SATURATE_EN to clamp the accumulator on
//                overflow instead of letting it wrap (two's complement).
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    // State encoding: ACCUM collects terms, DONE holds a result for handoff
    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_DONE  = 1'b1;

    // Count value that, once one more term arrives, forces the result closed
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(MAX_TERMS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

`ifdef MAC_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf_pos;
    logic             w_ovf_neg;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ovf_next;
    logic             w_beat;
    logic             w_close;

    // Term arithmetic: sign-extend, add, and flag overflow from operand/sum signs
    assign w_ext        = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign w_sum        = r_acc + w_ext;
    assign w_ovf_pos    = ~r_acc[ACC_W-1] & ~w_ext[ACC_W-1] &  w_sum[ACC_W-1];
    assign w_ovf_neg    =  r_acc[ACC_W-1] &  w_ext[ACC_W-1] & ~w_sum[ACC_W-1];
    assign w_count_next = r_count + c_CNT_ONE;
    assign w_ovf_next   = r_ovf | w_ovf_pos | w_ovf_neg;

`ifdef MAC_ACC_SATURATE_EN
    // Clamp toward the side the overflow went; later terms resume from the rail
    assign w_acc_next = w_ovf_pos ? c_ACC_MAX :
                        w_ovf_neg ? c_ACC_MIN : w_sum;
`else
    // Plain two's-complement wrap
    assign w_acc_next = w_sum;
`endif

    // A beat closes the result on in_last or when the term budget is used up;
    // clear overrides a concurrent beat so that term never produces a result
    assign w_beat  = in_valid & in_ready;
    assign w_close = w_beat & ~clear & (in_last | (r_count == c_LAST_CNT));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: close moves to DONE, downstream acceptance returns
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_ACCUM: if (w_close)   w_state_next = c_ST_DONE;
            c_ST_DONE:  if (out_ready) w_state_next = c_ST_ACCUM;
            default:                   w_state_next = c_ST_ACCUM;
        endcase
    end

    // Output decode: terms are only accepted while accumulating
    always_comb begin
        in_ready = (r_state == c_ST_ACCUM);
    end

    // Datapath: partial sum bookkeeping and result capture/handoff
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (r_state == c_ST_ACCUM) begin
            if (clear) begin
                r_acc   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_close) begin
                out_data  <= w_acc_next;
                out_count <= w_count_next;
                out_ovf   <= w_ovf_next;
                out_valid <= 1'b1;
                r_acc     <= '0;
                r_count   <= '0;
                r_ovf     <= 1'b0;
            end else if (w_beat) begin
                r_acc   <= w_acc_next;
                r_count <= w_count_next;
                r_ovf   <= w_ovf_next;
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_accumulator
//  Description : Self-checking bench for mac_accumulator. Two instances share
//                the stimulus: one at ACC_W=16 and one at ACC_W=9 so that the
//                overflow behaviour (wrap or, with MAC_ACC_SATURATE_EN, clamp)
//                is exercised. An integer-arithmetic model predicts results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

    localparam int MAXT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready16, in_ready9;
    logic [15:0] out_data16;
    logic [8:0]  out_data9;
    logic [4:0]  out_count16, out_count9;
    logic        out_ovf16, out_ovf9;
    logic        out_valid16, out_valid9;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.IN_W(8), .ACC_W(16), .MAX_TERMS(MAXT), .CNT_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready16),
        .out_data(out_data16), .out_count(out_count16), .out_ovf(out_ovf16),
        .out_valid(out_valid16), .out_ready(out_ready)
    );

    mac_accumulator #(.IN_W(8), .ACC_W(9), .MAX_TERMS(MAXT), .CNT_W(5)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready9),
        .out_data(out_data9), .out_count(out_count9), .out_ovf(out_ovf9),
        .out_valid(out_valid9), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: whole-integer arithmetic with range checks
    // ------------------------------------------------------------------
    function automatic void add_term(input int acc, input int term, input int w,
                                     output int res, output bit ov);
        int lo, hi, t;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        t  = acc + term;
        ov = (t > hi) || (t < lo);
`ifdef MAC_ACC_SATURATE_EN
        res = (t > hi) ? hi : (t < lo) ? lo : t;
`else
        res = (t > hi) ? t - (1 << w) : (t < lo) ? t + (1 << w) : t;
`endif
    endfunction

    bit m_live = 0;
    bit m_pend = 0;
    int m_acc16 = 0, m_acc9 = 0, m_cnt = 0;
    bit m_ovf16 = 0, m_ovf9 = 0;
    int e_data16 = 0, e_data9 = 0, e_cnt = 0;
    bit e_ovf16 = 0, e_ovf9 = 0;

    always @(posedge clk) begin
        int  r16, r9;
        bit  v16, v9;
        if (!rst_n) begin
            m_live = 1; m_pend = 0;
            m_acc16 = 0; m_acc9 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf9 = 0;
        end else if (!m_pend) begin
            if (clear) begin
                m_acc16 = 0; m_acc9 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf9 = 0;
            end else if (in_valid) begin
                add_term(m_acc16, int'($signed(in_data)), 16, r16, v16);
                add_term(m_acc9,  int'($signed(in_data)), 9,  r9,  v9);
                m_acc16 = r16; m_acc9 = r9;
                m_ovf16 = m_ovf16 | v16; m_ovf9 = m_ovf9 | v9;
                m_cnt++;
                if (in_last || m_cnt == MAXT) begin
                    e_data16 = m_acc16; e_data9 = m_acc9; e_cnt = m_cnt;
                    e_ovf16 = m_ovf16; e_ovf9 = m_ovf9;
                    m_pend = 1;
                    m_acc16 = 0; m_acc9 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf9 = 0;
                end
            end
        end else if (out_ready) begin
            m_pend = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready16", in_ready16, !m_pend);
            check("in_ready9",  in_ready9,  !m_pend);
            check("out_valid16", out_valid16, m_pend);
            check("out_valid9",  out_valid9,  m_pend);
            if (m_pend) begin
                check("out_data16",  $signed(out_data16), e_data16);
                check("out_count16", out_count16, e_cnt);
                check("out_ovf16",   out_ovf16, e_ovf16);
                check("out_data9",   $signed(out_data9), e_data9);
                check("out_count9",  out_count9, e_cnt);
                check("out_ovf9",    out_ovf9, e_ovf9);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literals
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic term(input int v, input bit last);
        in_valid = 1'b1;
        in_data  = 8'(v);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // 1. Reset held with a term presented
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'd50;
        step(); step();
        check("rst_valid", out_valid16, 0);
        check("rst_data",  out_data16, 0);
        check("rst_ready", in_ready16, 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // 2. Simple sum
        out_ready = 1'b1;
        term(5, 0); term(-3, 0); term(127, 0); term(-128, 1);
        check("sum_valid", out_valid16, 1);
        check("sum_data",  $signed(out_data16), 1);
        check("sum_count", out_count16, 4);
        check("sum_ovf",   out_ovf16, 0);
        check("sum_ready_done", in_ready16, 0);
        check("sum_data9", $signed(out_data9), 1);
        step();
        check("sum_drop", out_valid16, 0);
        check("sum_ready_back", in_ready16, 1);

        // 3. Forced close with backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) term(100, 0);
        check("force_data",  $signed(out_data16), 1600);
        check("force_count", out_count16, 16);
`ifdef MAC_ACC_SATURATE_EN
        check("force_data9", $signed(out_data9), 255);
`else
        check("force_data9", $signed(out_data9), 64);
`endif
        check("force_ovf9", out_ovf9, 1);
        in_valid = 1'b1; in_data = 8'd9; clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", out_valid16, 1);
            check("hold_data",  $signed(out_data16), 1600);
            check("hold_ready", in_ready16, 0);
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        step();
        check("force_drop", out_valid16, 0);

        // 4. Clear aborts the partial sum, including a closing beat
        in_last = 1'b1; step(); in_last = 1'b0;
        term(10, 0); term(20, 0);
        clear = 1'b1; term(30, 1); clear = 1'b0;
        check("clr_novalid", out_valid16, 0);
        term(7, 1);
        check("clr_data",  $signed(out_data16), 7);
        check("clr_count", out_count16, 1);
        step();

        // 5. Overflow on the narrow instance
        term(127, 0); term(127, 0); term(127, 1);
        check("ovf_data16", $signed(out_data16), 381);
        check("ovf_ovf16",  out_ovf16, 0);
`ifdef MAC_ACC_SATURATE_EN
        check("ovf_data9", $signed(out_data9), 255);
`else
        check("ovf_data9", $signed(out_data9), -131);
`endif
        check("ovf_ovf9",   out_ovf9, 1);
        check("ovf_count9", out_count9, 3);
        step();

        // 6. Reset while a result is pending
        out_ready = 1'b0;
        term(3, 0); term(4, 1);
        check("mid_valid", out_valid16, 1);
        check("mid_data",  $signed(out_data16), 7);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("mid_rst_valid", out_valid16, 0);
        check("mid_rst_data",  out_data16, 0);
        check("mid_rst_ready", in_ready16, 1);
        out_ready = 1'b1;
        term(2, 1);
        check("post_data",  $signed(out_data16), 2);
        check("post_count", out_count16, 1);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
